// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, constants and fetch-queue payload.
package cpu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [WIDTH-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push, pop and flush.
// Callers guarantee pop only when non-empty and push only when not full or popping.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t wr_data,
  output fq_entry_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t       entries [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Pointer and occupancy update; flush empties the queue but leaves storage untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= wr_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rd_data = entries[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, icache capture into the fetch queue,
// and taken-branch redirect handling.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      FQ_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] instruction,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             fq_valid,
  output logic [WIDTH-1:0] fq_instr,
  output logic [WIDTH-1:0] fq_pc,
  input  logic             fq_ready
);

  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] pc_next;
  fq_entry_t        wr_entry;
  fq_entry_t        head;

  // Handshake decode; a redirect suppresses the push of the wrong-path fetch.
  always_comb begin
    pop  = ~empty & fq_ready;
    push = fetch_en & ~redirect_valid & (~full | pop);
  end

  // Next fetch address: redirect target word-aligned, else step on push, else hold.
  always_comb begin
    pc_next = PC;
    if (redirect_valid) begin
      pc_next = redirect_pc & ~WIDTH'(3);
    end else if (push) begin
      pc_next = PC + PC_STEP;
    end
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC <= RESET_PC;
    end else begin
      PC <= pc_next;
    end
  end

  assign wr_entry.pc    = PC;
  assign wr_entry.instr = instruction;

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk    (CLK),
    .rst    (RST),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_data(wr_entry),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );

  assign fq_valid = ~empty;
  assign fq_instr = head.instr;
  assign fq_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic        fq_ready;

  logic [31:0] icache [16];

  fq_entry_t   mq[$];
  logic [31:0] mpc;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .FQ_DEPTH(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PC            (PC),
    .instruction   (instruction),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fq_valid      (fq_valid),
    .fq_instr      (fq_instr),
    .fq_pc         (fq_pc),
    .fq_ready      (fq_ready)
  );

  always #5 CLK = ~CLK;

  assign instruction = icache[PC[5:2]];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic r, input logic fe, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    bit        mpop;
    bit        mpush;
    fq_entry_t e;
    RST            = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    fq_ready       = rdy;
    @(posedge CLK);
    if (r) begin
      mq.delete();
      mpc = RST_PC;
    end else if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      mpop  = (mq.size() != 0) && rdy;
      mpush = fe && ((mq.size() < DEPTH) || mpop);
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        e.pc    = mpc;
        e.instr = icache[mpc[5:2]];
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    #1;
    check_eq("pc", PC, mpc);
    check_eq("fq_valid", 32'(fq_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("fq_pc", fq_pc, mq[0].pc);
      check_eq("fq_instr", fq_instr, mq[0].instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) icache[i] = $urandom;
    RST = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fq_ready = 1'b0;
    mpc = RST_PC;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h44, 1);
    check_eq("rst_fq_pc", fq_pc, 32'h0);
    check_eq("rst_fq_instr", fq_instr, 32'h0);

    // Streaming fetch with issue always ready
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1);
    check_eq("stream_pc", PC, 32'h20);

    // Fill with issue stalled, then drain (also full+pop same cycle)
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    check_eq("full_hold_pc", PC, 32'h10);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);

    // Redirect with 3 entries queued
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h3A, 1);
    check_eq("redir_valid", 32'(fq_valid), 32'h0);
    check_eq("redir_pc", PC, 32'h38);
    step(0, 1, 0, 0, 0);
    check_eq("redir_head", fq_pc, 32'h38);
    step(0, 1, 0, 0, 1);

    // PC wrap and fetch_en=0 hold
    step(0, 1, 1, 32'hFFFF_FFFE, 1);
    step(0, 1, 0, 0, 1);
    check_eq("wrap_pc", PC, 32'h0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("hold_pc", PC, 32'h0);
    step(0, 1, 0, 0, 0);

    // Reset mid-stream beats a simultaneous redirect
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h80, 1);
    check_eq("midrst_pc", PC, RST_PC);
    check_eq("midrst_valid", 32'(fq_valid), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0),
           $urandom,
           ($urandom_range(0, 4) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
